inst_mem_responder: RTL and testbench

INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

---
 rtl/inst_mem_responder.sv | 119 +++++++++++
 tb/tb_inst_mem_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_responder.sv
// Instruction memory responder: a fetch-side slave with a fixed wait-state latency,
// a misalignment/range error response, branch flush and a program-load write port.
module inst_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_instruction,
    output logic        resp_error,
    input  logic        flush,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);
    localparam int          AW  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP = 32'hE1A00000;
    localparam logic [3:0]  WS  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [31:0] mem_q [DEPTH_WORDS];
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic        rdy_q;
    logic        resp_valid_q;
    logic        resp_error_q;
    logic [31:0] resp_instr_q;

    logic [31:0] fetch_addr_d;
    logic        fetch_bad_d;
    logic [31:0] fetch_word_d;
    logic        accept;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return a[AW+1:2];
    endfunction

    // In IDLE the read comes straight from the request so a zero-wait build can respond next cycle.
    always_comb begin
        fetch_addr_d = (state_q == S_IDLE) ? req_addr : addr_q;
        fetch_bad_d  = addr_bad(fetch_addr_d);
        fetch_word_d = fetch_bad_d ? NOP : mem_q[word_idx(fetch_addr_d)];
    end

    assign req_ready        = rdy_q && (state_q == S_IDLE) && !flush && !load_en;
    assign accept           = req_valid && req_ready;
    assign resp_valid       = resp_valid_q;
    assign resp_error       = resp_error_q;
    assign resp_instruction = resp_instr_q;

    always_ff @(posedge clk) begin
        if (load_en && (state_q == S_IDLE) && !addr_bad(load_addr)) begin
            mem_q[word_idx(load_addr)] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= 32'd0;
            rdy_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_instr_q <= 32'd0;
        end else begin
            rdy_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr;
                        if (WS == 4'd0) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_instr_q <= fetch_word_d;
                            resp_error_q <= fetch_bad_d;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= WS;
                        end
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q == 4'd1) begin
                        // Counter reaches zero on the same edge the response is launched.
                        cnt_q        <= 4'd0;
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_instr_q <= fetch_word_d;
                        resp_error_q <= fetch_bad_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (flush || resp_ready) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_mem_responder.sv
// Scoreboard bench: instance A uses two wait states, instance B uses zero wait states.
module tb_inst_mem_responder;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        load_en;
    logic [31:0] load_addr, load_data;
    logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready, a_resp_error, a_flush;
    logic [31:0] a_req_addr, a_resp_instruction;
    logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_error, b_flush;
    logic [31:0] b_req_addr, b_resp_instruction;

    inst_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_addr(a_req_addr),
        .req_ready(a_req_ready), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_instruction(a_resp_instruction), .resp_error(a_resp_error), .flush(a_flush),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    inst_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_addr(b_req_addr),
        .req_ready(b_req_ready), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_instruction(b_resp_instruction), .resp_error(b_resp_error), .flush(b_flush),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   a_in     = 1'b0;
    bit   b_in     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event seen or missing contrary to expectation", name);
    endtask

    // Monitors: first visible cycle is checked against latency, data on every valid cycle.
    always @(negedge clk) begin
        if (a_resp_valid === 1'b1) begin
            if (sb_a.size() == 0) fail("a_unexpected_resp");
            else begin
                if (!a_in) chk("a_latency", cyc, sb_a[0].cyc);
                chk("a_instr", a_resp_instruction, sb_a[0].instr);
                chk("a_err", {31'd0, a_resp_error}, {31'd0, sb_a[0].err});
                if (a_resp_ready === 1'b1) void'(sb_a.pop_front());
            end
            a_in = (a_resp_ready !== 1'b1);
        end else a_in = 1'b0;
    end

    always @(negedge clk) begin
        if (b_resp_valid === 1'b1) begin
            if (sb_b.size() == 0) fail("b_unexpected_resp");
            else begin
                if (!b_in) chk("b_latency", cyc, sb_b[0].cyc);
                chk("b_instr", b_resp_instruction, sb_b[0].instr);
                chk("b_err", {31'd0, b_resp_error}, {31'd0, sb_b[0].err});
                if (b_resp_ready === 1'b1) void'(sb_b.pop_front());
            end
            b_in = (b_resp_ready !== 1'b1);
        end else b_in = 1'b0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        #1;
        chk("ready_during_load", {31'd0, a_req_ready}, 32'd0);
        step();
        load_en = 1'b0;
    endtask

    task automatic fetch(input bit sel_b, input logic [31:0] addr,
                         input logic [31:0] instr, input logic err);
        int ws;
        bit got;
        ws  = sel_b ? 0 : 2;
        got = 1'b0;
        if (sel_b) begin b_req_valid = 1'b1; b_req_addr = addr; end
        else begin a_req_valid = 1'b1; a_req_addr = addr; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((sel_b ? b_req_ready : a_req_ready) === 1'b1) got = 1'b1;
        end
        if (!got) fail("req_ready_timeout");
        else if (sel_b) sb_b.push_back('{instr, err, cyc + ws + 1});
        else sb_a.push_back('{instr, err, cyc + ws + 1});
        step();
        if (sel_b) b_req_valid = 1'b0;
        else a_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            #1;
            if (sb_a.size() == 0 && sb_b.size() == 0 && a_resp_valid !== 1'b1 && b_resp_valid !== 1'b1)
                done = 1'b1;
        end
        if (!done) fail("resp_timeout");
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        a_req_valid = 1'b0; a_req_addr = '0; a_resp_ready = 1'b1; a_flush = 1'b0;
        b_req_valid = 1'b0; b_req_addr = '0; b_resp_ready = 1'b1; b_flush = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
        chk("rst_resp_error", {31'd0, a_resp_error}, 32'd0);
        chk("rst_resp_instr", a_resp_instruction, 32'd0);
        chk("rst_req_ready", {31'd0, a_req_ready}, 32'd0);
        step();
        rst = 1'b1;
        #1;
        chk("ready_before_edge", {31'd0, a_req_ready}, 32'd0);
        step();
        chk("ready_after_edge_a", {31'd0, a_req_ready}, 32'd1);
        chk("ready_after_edge_b", {31'd0, b_req_ready}, 32'd1);

        // Program load, including ignored misaligned and out-of-range writes
        do_load(32'd0,   32'hE3A01005);
        do_load(32'd4,   32'hE3A02007);
        do_load(32'd8,   32'hE0813002);
        do_load(32'd20,  32'hE2811001);
        do_load(32'd252, 32'h12345678);
        do_load(32'd5,   32'hDEADBEEF);
        do_load(32'd256, 32'hCAFEBABE);

        // Normal fetches
        fetch(1'b0, 32'd0,   32'hE3A01005, 1'b0); wait_idle();
        fetch(1'b0, 32'd4,   32'hE3A02007, 1'b0); wait_idle();
        fetch(1'b0, 32'd8,   32'hE0813002, 1'b0); wait_idle();
        fetch(1'b0, 32'd252, 32'h12345678, 1'b0); wait_idle();

        // Error responses
        fetch(1'b0, 32'd6,          32'hE1A00000, 1'b1); wait_idle();
        fetch(1'b0, 32'd256,        32'hE1A00000, 1'b1); wait_idle();
        fetch(1'b0, 32'hFFFF_FFFC,  32'hE1A00000, 1'b1); wait_idle();

        a_flush = 1'b1;
        #1;
        chk("ready_during_flush", {31'd0, a_req_ready}, 32'd0);
        a_flush = 1'b0;

        // Back-pressure: hold resp_ready low in RESP
        a_resp_ready = 1'b0;
        fetch(1'b0, 32'd8, 32'hE0813002, 1'b0);
        for (int i = 0; i < 10 && a_resp_valid !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("hold_resp_valid", {31'd0, a_resp_valid}, 32'd1);
            chk("hold_req_ready", {31'd0, a_req_ready}, 32'd0);
        end
        step();
        a_resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_req_ready", {31'd0, a_req_ready}, 32'd1);
        chk("release_resp_valid", {31'd0, a_resp_valid}, 32'd0);
        step();

        // Flush one cycle after accept drops the fetch
        fetch(1'b0, 32'd0, 32'hE3A01005, 1'b0);
        a_flush = 1'b1;
        void'(sb_a.pop_back());
        step();
        a_flush = 1'b0;
        repeat (6) @(negedge clk);
        chk("flush_no_resp", {31'd0, a_resp_valid}, 32'd0);
        step();
        fetch(1'b0, 32'd4, 32'hE3A02007, 1'b0); wait_idle();

        // Load during WAIT must be ignored
        fetch(1'b0, 32'd20, 32'hE2811001, 1'b0);
        do_load(32'd20, 32'hBAD0BAD0);
        wait_idle();
        fetch(1'b0, 32'd20, 32'hE2811001, 1'b0); wait_idle();

        // Reset during WAIT
        fetch(1'b0, 32'd4, 32'hE3A02007, 1'b0);
        rst = 1'b0;
        void'(sb_a.pop_back());
        #1;
        chk("rst_wait_resp_valid", {31'd0, a_resp_valid}, 32'd0);
        chk("rst_wait_req_ready", {31'd0, a_req_ready}, 32'd0);
        repeat (3) step();
        rst = 1'b1;
        step();

        // Reset during RESP clears resp_valid asynchronously
        a_resp_ready = 1'b0;
        fetch(1'b0, 32'd8, 32'hE0813002, 1'b0);
        for (int i = 0; i < 10 && a_resp_valid !== 1'b1; i++) @(negedge clk);
        step();
        rst = 1'b0;
        sb_a.delete();
        #1;
        chk("rst_resp_resp_valid", {31'd0, a_resp_valid}, 32'd0);
        chk("rst_resp_instr_clr", a_resp_instruction, 32'd0);
        a_resp_ready = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        step();

        // Memory survives reset
        fetch(1'b0, 32'd0,   32'hE3A01005, 1'b0); wait_idle();
        fetch(1'b0, 32'd252, 32'h12345678, 1'b0); wait_idle();

        // Zero-wait instance: back-to-back fetches
        fetch(1'b1, 32'd0, 32'hE3A01005, 1'b0);
        fetch(1'b1, 32'd4, 32'hE3A02007, 1'b0);
        fetch(1'b1, 32'd8, 32'hE0813002, 1'b0);
        wait_idle();
        fetch(1'b1, 32'd6, 32'hE1A00000, 1'b1);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
